alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1, meaning: 1 = round-robin grant between requesters, 0 = fixed priority with req0 always winning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 ALUControl code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op SHALL mirror REQ-004..007 for requester 1.
REQ-009 alu_A, alu_B  output  32 each  operands driven to the shared ALU.
REQ-010 alu_ALUControl  output  3  opcode driven to the shared ALU.
REQ-011 alu_Result  input  32  ALU result (combinational from alu_A/alu_B/alu_ALUControl).
REQ-012 alu_Zero  input  1  ALU zero flag.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_id  output  1  requester index owning the response.
REQ-016 rsp_result  output  32  captured ALU result.
REQ-017 rsp_zero, rsp_err  output  1 each  captured zero flag; illegal-opcode flag.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; exactly one transaction in flight at any time.
REQ-020 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only when that requester's valid is high; at most one ready high per cycle.
REQ-021 Grant with one valid requester: that requester.
REQ-022 Grant with both valid, FAIR=1: the requester not granted last (last_grant register); FAIR=0: requester 0.
REQ-023 Handshake (valid & ready at edge): latch a, b, op, id; update last_grant; go to EXEC, or to RESP directly if op is illegal.
REQ-024 Legal ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (signed); 100, 110, 111 are illegal.
REQ-025 Illegal op: skip EXEC; rsp_result=0, rsp_zero=0, rsp_err=1; ALU not driven with that op.
REQ-026 EXEC lasts exactly one cycle: alu_A/alu_B/alu_ALUControl driven from latched values; at edge capture alu_Result/alu_Zero into rsp_result/rsp_zero, rsp_err=0, go to RESP.
REQ-027 Outside EXEC alu_A, alu_B SHALL be 0 and alu_ALUControl 000.
REQ-028 RESP: rsp_valid=1; rsp_id/result/zero/err stable until rsp_ready sampled high; then go to IDLE and rsp_valid=0 next cycle.
REQ-029 Latency: legal op rsp_valid rises 2 edges after handshake; illegal op 1 edge.
REQ-030 New handshake SHALL NOT occur in the cycle rsp handshake completes (earliest one cycle later, in IDLE); max throughput one op per 3 cycles.
REQ-031 Requester dropping valid before ready SHALL NOT be granted; no operation accepted without handshake.
REQ-032 Requester operand changes while not ready SHALL NOT affect an in-flight transaction.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, last_grant=1 (so req0 wins first contention), all outputs 0 including ready, rsp_*, busy, alu_*.
REQ-034 Reset mid-EXEC or mid-RESP SHALL discard the transaction; no response emitted after release.
REQ-035 First handshake possible on the first rising edge with rst_n high.

Verification
REQ-036 req0 ADD 10,20 alone -> req0_ready high same cycle; rsp_valid 2 edges later, result 0x0000001E, zero 0, id 0, err 0.
REQ-037 req0 SUB 15,15 and req1 OR FFFF0000,0000FFFF both valid after reset, FAIR=1 -> req0 first (result 0, zero 1), then req1 (result FFFFFFFF, id 1); FAIR=0 with req0 held valid -> req1 never granted.
REQ-038 req1 SLT FFFFFFFF,1 -> result 00000001, zero 0.
REQ-039 rsp_ready low 5 cycles in RESP -> rsp_* stable, both readys low, busy high; release -> IDLE next cycle.
REQ-040 req0 op 111 -> rsp_valid 1 edge after handshake, err 1, result 0, alu_ALUControl never 111.
REQ-041 rst_n pulsed low during EXEC -> outputs 0 asynchronously; no rsp_valid after release until a new handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared combinational ALU, one operation in flight
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/op (N=0,1)  requester handshake, operands and ALUControl opcode
//   alu_A, alu_B, alu_ALUControl     operands/opcode to the shared ALU (zero outside EXEC)
//   alu_Result, alu_Zero             combinational ALU outputs
//   rsp_valid/ready/id/result/zero/err  response handshake and captured result
//   busy                             high whenever a transaction is in flight
module alu_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_ALUControl,
    input  logic [31:0] alu_Result,
    input  logic        alu_Zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state;
    logic        last_grant;
    logic        grant1;
    logic        hs;
    logic        hs_bad;
    logic [31:0] hs_a;
    logic [31:0] hs_b;
    logic [2:0]  hs_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_code;
    // req1 wins when alone, or on contention in fair mode when req0 was served last
    assign grant1     = req1_valid && (!req0_valid || (FAIR != 0 && !last_grant));
    // gated by rst_n so no ready is ever offered while reset is asserted
    assign req0_ready = rst_n && state == IDLE && req0_valid && !grant1;
    assign req1_ready = rst_n && state == IDLE && req1_valid && grant1;
    assign hs         = req0_ready || req1_ready;
    assign hs_a       = grant1 ? req1_a : req0_a;
    assign hs_b       = grant1 ? req1_b : req0_b;
    assign hs_op      = grant1 ? req1_op : req0_op;
    // 100, 110 and 111 have no ALU function; they bypass EXEC and never reach the ALU
    assign hs_bad     = hs_op[2] && hs_op[1:0] != 2'b01;
    assign alu_A          = state == EXEC ? op_a : '0;
    assign alu_B          = state == EXEC ? op_b : '0;
    assign alu_ALUControl = state == EXEC ? op_code : '0;
    assign rsp_valid      = state == RESP;
    assign busy           = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    op_a       <= hs_a;
                    op_b       <= hs_b;
                    op_code    <= hs_op;
                    rsp_id     <= grant1;
                    last_grant <= grant1;
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                    rsp_err    <= hs_bad;
                    state      <= hs_bad ? RESP : EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_Result;
                    rsp_zero   <= alu_Zero;
                    rsp_err    <= 1'b0;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err, busy, alu_Zero;
    logic [31:0] alu_A, alu_B, alu_Result, rsp_result;
    logic [2:0]  alu_ALUControl;
    logic        f_v0 = 1'b0, f_v1 = 1'b0, f_rr = 1'b1;
    logic [31:0] f_a = 32'd3, f_b = 32'd4;
    logic [2:0]  f_op = 3'd0;
    logic        f_r0, f_r1, f_rsp_valid, f_rsp_id, f_rsp_zero, f_rsp_err, f_busy, f_alu_Zero;
    logic [31:0] f_alu_A, f_alu_B, f_alu_Result, f_rsp_result;
    logic [2:0]  f_alu_ALUControl;
    int          checks = 0, failures = 0;
    bit          m_act, m_last, m_id, m_zero, m_err;
    int          m_wait;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_op;
    always #5 clk = ~clk;
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction
    function automatic bit legal(input logic [2:0] op);
        return op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    endfunction
    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction
    assign alu_Result   = alu_f(alu_A, alu_B, alu_ALUControl);
    assign alu_Zero     = alu_Result == 32'h0;
    assign f_alu_Result = alu_f(f_alu_A, f_alu_B, f_alu_ALUControl);
    assign f_alu_Zero   = f_alu_Result == 32'h0;
    alu_arbiter #(.FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUControl(alu_ALUControl), .alu_Result(alu_Result), .alu_Zero(alu_Zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );
    alu_arbiter #(.FAIR(0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_v0), .req0_ready(f_r0), .req0_a(f_a), .req0_b(f_b), .req0_op(f_op),
        .req1_valid(f_v1), .req1_ready(f_r1), .req1_a(f_b), .req1_b(f_a), .req1_op(f_op),
        .alu_A(f_alu_A), .alu_B(f_alu_B), .alu_ALUControl(f_alu_ALUControl), .alu_Result(f_alu_Result), .alu_Zero(f_alu_Zero),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rr), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result),
        .rsp_zero(f_rsp_zero), .rsp_err(f_rsp_err), .busy(f_busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic v0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic rr);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        rsp_ready = rr;
    endtask
    // one clock: compare against the model, advance the model across the edge, return at next negedge
    task automatic cycle();
        int win;
        bit exec;
        #1;
        win = -1;
        if (!m_act) begin
            if (req0_valid && req1_valid) win = m_last ? 0 : 1;
            else if (req0_valid) win = 0;
            else if (req1_valid) win = 1;
        end
        exec = m_act && m_wait == 1;
        check("req0_ready", 32'(req0_ready), 32'(win == 0));
        check("req1_ready", 32'(req1_ready), 32'(win == 1));
        check("busy", 32'(busy), 32'(m_act));
        check("rsp_valid", 32'(rsp_valid), 32'(m_act && m_wait == 0));
        check("alu_A", alu_A, exec ? m_a : 32'h0);
        check("alu_B", alu_B, exec ? m_b : 32'h0);
        check("alu_op", 32'(alu_ALUControl), exec ? 32'(m_op) : 32'h0);
        if (m_act && m_wait == 0) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_result", rsp_result, m_res);
            check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
            check("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        if (win >= 0) begin
            m_act  = 1'b1;
            m_id   = win[0];
            m_last = win[0];
            m_a    = win == 1 ? req1_a : req0_a;
            m_b    = win == 1 ? req1_b : req0_b;
            m_op   = win == 1 ? req1_op : req0_op;
            m_wait = legal(m_op) ? 1 : 0;
            m_res  = legal(m_op) ? alu_f(m_a, m_b, m_op) : 32'h0;
            m_zero = legal(m_op) && m_res == 32'h0;
            m_err  = !legal(m_op);
        end else if (m_act && m_wait == 1) m_wait = 0;
        else if (m_act && rsp_ready) m_act = 1'b0;
        @(negedge clk);
    endtask
    task automatic expect_rsp(input string t, input logic id, input logic [31:0] res, input logic z, input logic e);
        check({t, "_valid"}, 32'(rsp_valid), 32'd1);
        check({t, "_id"}, 32'(rsp_id), 32'(id));
        check({t, "_result"}, rsp_result, res);
        check({t, "_zero"}, 32'(rsp_zero), 32'(z));
        check({t, "_err"}, 32'(rsp_err), 32'(e));
    endtask
    // asserts reset between edges, checks the asynchronous clear, releases at the next negedge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_rsp_flags", {29'd0, rsp_id, rsp_zero, rsp_err}, 32'h0);
        check("rst_alu_A", alu_A, 32'h0);
        check("rst_alu_B", alu_B, 32'h0);
        check("rst_alu_op", 32'(alu_ALUControl), 32'h0);
        m_act  = 1'b0;
        m_last = 1'b1;
        m_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        int grants;
        drive(1'b1, 3'd0, 32'd5, 32'd6, 1'b1, 3'd0, 32'd7, 32'd8, 1'b1);
        do_reset();
        drive(1'b1, 3'd0, 32'd10, 32'd20, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        expect_rsp("add", 1'b0, 32'h0000001E, 1'b0, 1'b0);
        cycle();
        do_reset();
        drive(1'b1, 3'd1, 32'd15, 32'd15, 1'b1, 3'd3, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
        cycle();
        cycle();
        expect_rsp("sub", 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) cycle();
        expect_rsp("or", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'd5, 32'hFFFFFFFF, 32'd1, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        expect_rsp("slt", 1'b1, 32'h00000001, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        cycle();
        drive(1'b1, 3'd0, 32'd1, 32'd1, 1'b1, 3'd0, 32'd2, 32'd2, 1'b0);
        cycle();
        expect_rsp("stall", 1'b0, 32'hF000F000, 1'b0, 1'b0);
        repeat (5) begin
            cycle();
            expect_rsp("stall", 1'b0, 32'hF000F000, 1'b0, 1'b0);
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        #1 check("stall_idle_busy", 32'(busy), 32'd0);
        drive(1'b1, 3'd7, 32'd1, 32'd2, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        expect_rsp("bad", 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        #1 check("exec_alu_A", alu_A, 32'd3);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        do_reset();
        repeat (4) cycle();
        repeat (800) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd(), rnd(),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd(), rnd(),
                  1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cycle();
        f_v0 = 1'b1;
        f_v1 = 1'b1;
        grants = 0;
        repeat (30) begin
            #1;
            check("fix_req1_ready", 32'(f_r1), 32'd0);
            grants += int'(f_r0);
            @(negedge clk);
        end
        check("fix_req0_grants", 32'(grants), 32'd10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
